// File: rtl/xillybus_mem_bank_if.sv
// Host stream pair (mem read / mem write / seek) plus the application-side
// port of xillybus_mem_bank. master = host + application side, slave = bank.
interface xillybus_mem_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              user_r_mem_rden;
  logic [DATA_W-1:0] user_r_mem_data;
  logic              user_r_mem_empty;
  logic              user_r_mem_eof;
  logic              user_r_mem_open;
  logic              user_w_mem_wren;
  logic [DATA_W-1:0] user_w_mem_data;
  logic              user_w_mem_full;
  logic              user_w_mem_open;
  logic [ADDR_W-1:0] user_mem_addr;
  logic              user_mem_addr_update;
  logic [ADDR_W-1:0] app_addr;
  logic              app_wren;
  logic [DATA_W-1:0] app_wdata;
  logic [DATA_W-1:0] app_rdata;
  logic              app_collision;

  modport master (
    output user_r_mem_rden, user_r_mem_open,
    input  user_r_mem_data, user_r_mem_empty, user_r_mem_eof,
    output user_w_mem_wren, user_w_mem_data, user_w_mem_open,
    input  user_w_mem_full,
    output user_mem_addr, user_mem_addr_update,
    output app_addr, app_wren, app_wdata,
    input  app_rdata, app_collision
  );

  modport slave (
    input  user_r_mem_rden, user_r_mem_open,
    output user_r_mem_data, user_r_mem_empty, user_r_mem_eof,
    input  user_w_mem_wren, user_w_mem_data, user_w_mem_open,
    output user_w_mem_full,
    input  user_mem_addr, user_mem_addr_update,
    input  app_addr, app_wren, app_wdata,
    output app_rdata, app_collision
  );
endinterface

// File: rtl/xillybus_mem_bank.sv
// Host-addressable memory bank behind a Xillybus seekable stream pair with a
// shared auto-incrementing pointer, a read prefetch stage and a second
// application-side port on the same storage.
// Optional: define XILLY_MEM_EOF_EN to stop the pointer at the last word
// (read reports eof, write reports full) instead of wrapping.
module xillybus_mem_bank #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int INIT_ZERO = 1
) (
  input  logic               bus_clk,
  input  logic               user_reset,
  xillybus_mem_bank_if.slave mem_if
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID
`ifdef XILLY_MEM_EOF_EN
    , S_END
`endif
  } rd_state_t;

  // Power-up contents only; reset never touches the array.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: {DATA_W{(INIT_ZERO != 0) ? 1'b0 : 1'bx}}};

  rd_state_t         rd_state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] app_rdata_q;
  logic              empty_q;
  logic              eof_q;
  logic              full_q;
  logic              r_open_d;
  logic              collision_q;

  logic host_wr;
  logic same_addr;
  logic app_wr;
  logic app_hits_ptr;
  logic rd_pop;
  logic ptr_last;

  assign ptr_last     = &ptr;
  assign same_addr    = (mem_if.app_addr == ptr);
  assign host_wr      = mem_if.user_w_mem_wren && mem_if.user_w_mem_open && !full_q
                        && !mem_if.user_mem_addr_update && !user_reset;
  assign app_wr       = mem_if.app_wren && !(host_wr && same_addr);
  assign app_hits_ptr = app_wr && same_addr;
  assign rd_pop       = mem_if.user_r_mem_rden && mem_if.user_r_mem_open
                        && (rd_state == S_VALID) && !mem_if.user_mem_addr_update && !host_wr;

  assign mem_if.user_r_mem_data  = rd_data;
  assign mem_if.user_r_mem_empty = empty_q;
  assign mem_if.user_r_mem_eof   = eof_q;
  assign mem_if.user_w_mem_full  = full_q;
  assign mem_if.app_rdata        = app_rdata_q;
  assign mem_if.app_collision    = collision_q;

  // Storage writes: host wins over the application port on an address clash.
  always_ff @(posedge bus_clk) begin
    if (app_wr) mem[mem_if.app_addr] <= mem_if.app_wdata;
    if (host_wr) mem[ptr] <= mem_if.user_w_mem_data;
  end

  // Application read port (old data on read-during-write) and collision flag.
  always_ff @(posedge bus_clk) begin
    if (user_reset) begin
      app_rdata_q <= '0;
      collision_q <= 1'b0;
    end else begin
      app_rdata_q <= mem[mem_if.app_addr];
      collision_q <= mem_if.app_wren && host_wr && same_addr;
    end
  end

  // Shared pointer, write back-pressure and read prefetch state machine.
  always_ff @(posedge bus_clk) begin
    if (user_reset) begin
      ptr      <= '0;
      rd_state <= S_IDLE;
      empty_q  <= 1'b1;
      eof_q    <= 1'b0;
      rd_data  <= '0;
      full_q   <= 1'b1;
      r_open_d <= 1'b0;
    end else begin
      r_open_d <= mem_if.user_r_mem_open;

      if (mem_if.user_mem_addr_update) begin
        ptr <= mem_if.user_mem_addr;
      end else if (host_wr || rd_pop) begin
`ifdef XILLY_MEM_EOF_EN
        if (!ptr_last) ptr <= ptr + 1'b1;
`else
        ptr <= ptr + 1'b1;
`endif
      end

`ifdef XILLY_MEM_EOF_EN
      if (mem_if.user_mem_addr_update || !mem_if.user_w_mem_open) full_q <= 1'b0;
      else if (host_wr && ptr_last) full_q <= 1'b1;
`else
      full_q <= 1'b0;
`endif

      if (!mem_if.user_r_mem_open) begin
        rd_state <= S_IDLE;
        empty_q  <= 1'b1;
        eof_q    <= 1'b0;
      end else if (mem_if.user_mem_addr_update || host_wr) begin
        rd_state <= S_FETCH;
        empty_q  <= 1'b1;
        eof_q    <= 1'b0;
      end else begin
        case (rd_state)
          S_IDLE: begin
            if (!r_open_d) rd_state <= S_FETCH;
          end
          // An app write landing on ptr during the fetch would make the
          // captured word stale, so the fetch is simply repeated.
          S_FETCH: begin
            rd_data <= mem[ptr];
            if (!app_hits_ptr) begin
              rd_state <= S_VALID;
              empty_q  <= 1'b0;
            end
          end
          S_VALID: begin
            if (rd_pop) begin
`ifdef XILLY_MEM_EOF_EN
              if (ptr_last) begin
                rd_state <= S_END;
                eof_q    <= 1'b1;
              end else begin
                rd_state <= S_FETCH;
              end
`else
              rd_state <= S_FETCH;
`endif
              empty_q <= 1'b1;
            end else if (app_hits_ptr) begin
              rd_state <= S_FETCH;
              empty_q  <= 1'b1;
            end
          end
`ifdef XILLY_MEM_EOF_EN
          S_END: begin
            rd_state <= S_END;
          end
`endif
          default: begin
            rd_state <= S_IDLE;
            empty_q  <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_xillybus_mem_bank.sv
// Directed self-checking bench for xillybus_mem_bank (DATA_W=8, ADDR_W=5).
module tb_xillybus_mem_bank;
  logic bus_clk = 1'b0;
  logic user_reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  xillybus_mem_bank_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  xillybus_mem_bank #(.DATA_W(8), .ADDR_W(5), .INIT_ZERO(1)) dut (
    .bus_clk    (bus_clk),
    .user_reset (user_reset),
    .mem_if     (bus.slave)
  );

  always #5 bus_clk = ~bus_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic seek(input logic [4:0] a);
    bus.user_mem_addr        = a;
    bus.user_mem_addr_update = 1'b1;
    tick();
    bus.user_mem_addr_update = 1'b0;
  endtask

  task automatic app_read(input logic [4:0] a, input logic [7:0] exp, input string tag);
    bus.app_addr = a;
    tick();
    check(tag, 32'(bus.app_rdata), 32'(exp));
  endtask

  task automatic host_write(input logic [7:0] d);
    bus.user_w_mem_wren = 1'b1;
    bus.user_w_mem_data = d;
    tick();
    bus.user_w_mem_wren = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    user_reset               = 1'b1;
    bus.user_r_mem_rden      = 1'b0;
    bus.user_r_mem_open      = 1'b0;
    bus.user_w_mem_wren      = 1'b0;
    bus.user_w_mem_data      = '0;
    bus.user_w_mem_open      = 1'b0;
    bus.user_mem_addr        = '0;
    bus.user_mem_addr_update = 1'b0;
    bus.app_addr             = '0;
    bus.app_wren             = 1'b0;
    bus.app_wdata            = '0;
    tick();
    tick();
    check("rst_empty", 32'(bus.user_r_mem_empty), 32'd1);
    check("rst_eof",   32'(bus.user_r_mem_eof),   32'd0);
    check("rst_data",  32'(bus.user_r_mem_data),  32'h0);
    check("rst_full",  32'(bus.user_w_mem_full),  32'd1);
    check("rst_app",   32'(bus.app_rdata),        32'h0);
    check("rst_coll",  32'(bus.app_collision),    32'd0);
    user_reset = 1'b0;
    tick();
    check("full_after_rst", 32'(bus.user_w_mem_full), 32'd0);

    // Host writes three words from address 0
    bus.user_w_mem_open = 1'b1;
    seek(5'd0);
    host_write(8'h11);
    host_write(8'h22);
    host_write(8'h33);
    app_read(5'd1, 8'h22, "app_rd1");
    app_read(5'd0, 8'h11, "app_rd0");
    app_read(5'd2, 8'h33, "app_rd2");

    // Seek 1 with read open: two-cycle prefetch latency, then pop
    bus.user_r_mem_open = 1'b1;
    seek(5'd1);
    check("seek_lat_empty", 32'(bus.user_r_mem_empty), 32'd1);
    tick();
    check("seek_empty", 32'(bus.user_r_mem_empty), 32'd0);
    check("seek_data",  32'(bus.user_r_mem_data),  32'h22);
    bus.user_r_mem_rden = 1'b1;
    tick();
    bus.user_r_mem_rden = 1'b0;
    check("pop_empty", 32'(bus.user_r_mem_empty), 32'd1);
    tick();
    check("pop2_empty", 32'(bus.user_r_mem_empty), 32'd0);
    check("pop2_data",  32'(bus.user_r_mem_data),  32'h33);

    // Write across the top of the address space
    seek(5'd31);
    host_write(8'hAA);
`ifdef XILLY_MEM_EOF_EN
    check("top_full", 32'(bus.user_w_mem_full), 32'd1);
`else
    check("top_full", 32'(bus.user_w_mem_full), 32'd0);
`endif
    host_write(8'hBB);
    app_read(5'd31, 8'hAA, "mem31");
`ifdef XILLY_MEM_EOF_EN
    app_read(5'd0, 8'h11, "mem0_sat");
    check("sat_rd_data", 32'(bus.user_r_mem_data), 32'hAA);
`else
    app_read(5'd0, 8'hBB, "mem0_wrap");
    check("wrap_rd_data", 32'(bus.user_r_mem_data), 32'h22);
`endif

    // Same-address host/app write: host wins, one-cycle pulse
    seek(5'd4);
    check("seek_clr_full", 32'(bus.user_w_mem_full), 32'd0);
    bus.user_w_mem_wren = 1'b1;
    bus.user_w_mem_data = 8'h5A;
    bus.app_wren        = 1'b1;
    bus.app_addr        = 5'd4;
    bus.app_wdata       = 8'hC3;
    tick();
    bus.user_w_mem_data = 8'h55;
    bus.app_addr        = 5'd6;
    bus.app_wdata       = 8'h66;
    check("coll_pulse", 32'(bus.app_collision), 32'd1);
    tick();
    bus.user_w_mem_wren = 1'b0;
    bus.app_wren        = 1'b0;
    check("coll_clear", 32'(bus.app_collision), 32'd0);
    app_read(5'd4, 8'h5A, "coll_host_wins");
    app_read(5'd5, 8'h55, "host_wr5");
    app_read(5'd6, 8'h66, "app_wr6");

    // App write onto the word held in VALID forces a refetch
    seek(5'd2);
    tick();
    check("valid2_data", 32'(bus.user_r_mem_data), 32'h33);
    bus.app_wren  = 1'b1;
    bus.app_addr  = 5'd2;
    bus.app_wdata = 8'h77;
    tick();
    bus.app_wren = 1'b0;
    check("stale_empty", 32'(bus.user_r_mem_empty), 32'd1);
    tick();
    check("fresh_empty", 32'(bus.user_r_mem_empty), 32'd0);
    check("fresh_data",  32'(bus.user_r_mem_data),  32'h77);

    // Pop the last word
    seek(5'd31);
    tick();
    check("last_data", 32'(bus.user_r_mem_data), 32'hAA);
    bus.user_r_mem_rden = 1'b1;
    tick();
    bus.user_r_mem_rden = 1'b0;
    check("last_pop_empty", 32'(bus.user_r_mem_empty), 32'd1);
    tick();
`ifdef XILLY_MEM_EOF_EN
    check("end_eof",   32'(bus.user_r_mem_eof),   32'd1);
    check("end_empty", 32'(bus.user_r_mem_empty), 32'd1);
    tick();
    check("end_hold", 32'(bus.user_r_mem_eof), 32'd1);
`else
    check("wrap_eof",  32'(bus.user_r_mem_eof),  32'd0);
    check("wrap_data", 32'(bus.user_r_mem_data), 32'hBB);
`endif
    seek(5'd0);
    tick();
    check("reseek_eof",   32'(bus.user_r_mem_eof),   32'd0);
    check("reseek_empty", 32'(bus.user_r_mem_empty), 32'd0);
`ifdef XILLY_MEM_EOF_EN
    check("reseek_data", 32'(bus.user_r_mem_data), 32'h11);
`else
    check("reseek_data", 32'(bus.user_r_mem_data), 32'hBB);
`endif

    // addr_update drops a concurrent wren, then a concurrent rden
    bus.app_wren  = 1'b1;
    bus.app_addr  = 5'd12;
    bus.app_wdata = 8'hC0;
    tick();
    bus.app_wren        = 1'b0;
    bus.user_w_mem_wren = 1'b1;
    bus.user_w_mem_data = 8'hEE;
    seek(5'd8);
    bus.user_w_mem_wren = 1'b0;
    tick();
    check("upd_wr_data", 32'(bus.user_r_mem_data), 32'h00);
`ifdef XILLY_MEM_EOF_EN
    app_read(5'd0, 8'h11, "upd_wr_dropped");
`else
    app_read(5'd0, 8'hBB, "upd_wr_dropped");
`endif
    host_write(8'h88);
    app_read(5'd8, 8'h88, "upd_ptr8");
    tick();
    bus.user_r_mem_rden = 1'b1;
    seek(5'd12);
    bus.user_r_mem_rden = 1'b0;
    tick();
    check("upd_rd_empty", 32'(bus.user_r_mem_empty), 32'd0);
    check("upd_rd_data",  32'(bus.user_r_mem_data),  32'hC0);

    // Reset mid-read: state and pointer return, storage is retained
    user_reset = 1'b1;
    tick();
    check("mid_rst_empty", 32'(bus.user_r_mem_empty), 32'd1);
    check("mid_rst_data",  32'(bus.user_r_mem_data),  32'h00);
    user_reset = 1'b0;
    tick();
    check("post_rst_empty", 32'(bus.user_r_mem_empty), 32'd1);
    tick();
    check("post_rst_valid", 32'(bus.user_r_mem_empty), 32'd0);
`ifdef XILLY_MEM_EOF_EN
    check("post_rst_ptr0", 32'(bus.user_r_mem_data), 32'h11);
`else
    check("post_rst_ptr0", 32'(bus.user_r_mem_data), 32'hBB);
`endif
    app_read(5'd1, 8'h22, "mem_retained");

    bus.user_r_mem_open = 1'b0;
    tick();
    check("close_empty", 32'(bus.user_r_mem_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/xillybus_mem_bank.md
Name: xillybus_mem_bank

Overview:
- Parametrised host-addressable memory bank behind one Xillybus seekable stream pair: mem read, mem write, address, address-update.
- Generalises the fixed 8-bit/5-bit-address mem stream to DATA_W/ADDR_W, with an auto-incrementing shared pointer and a read prefetch stage.
- Adds a second, application-side port so fabric logic can read and write the same storage.
- Sits between the Xillybus core user interface and the application, clocked by bus_clk.

Parameters:
- DATA_W, 8, word width of both ports.
- ADDR_W, 5, address width. DEPTH = 2**ADDR_W words.
- INIT_ZERO, 1, if 1 the memory contents power up as zero (simulation and bitstream init); reset does not clear the RAM.

Ports:
- bus_clk  in  1  sole clock.
- user_reset  in  1  synchronous, active-high reset.
- user_r_mem_rden  in  1  host read strobe; pops the presented word.
- user_r_mem_data  out  DATA_W  word at the pointer, valid while empty=0.
- user_r_mem_empty  out  1  no valid prefetched word.
- user_r_mem_eof  out  1  end-of-file (optional feature only).
- user_r_mem_open  in  1  host read file open.
- user_w_mem_wren  in  1  host write strobe.
- user_w_mem_data  in  DATA_W  host write data.
- user_w_mem_full  out  1  write back-pressure.
- user_w_mem_open  in  1  host write file open.
- user_mem_addr  in  ADDR_W  seek address.
- user_mem_addr_update  in  1  load pointer from user_mem_addr.
- app_addr  in  ADDR_W  application port address.
- app_wren  in  1  application write enable.
- app_wdata  in  DATA_W  application write data.
- app_rdata  out  DATA_W  data at app_addr, registered, 1-cycle latency.
- app_collision  out  1  one-cycle pulse: app write dropped due to same-cycle host write to the same address.

Behaviour:
- Reset values: ptr=0, read state IDLE, empty=1, eof=0, user_r_mem_data=0, full=1 during reset and 0 from the first cycle after, app_rdata=0, app_collision=0.
- Single pointer ptr[ADDR_W-1:0] is shared by read and write, as Xillybus seekable streams require.
- Priority per cycle: user_mem_addr_update > wren > rden.
  - addr_update: ptr <= user_mem_addr; any concurrent wren/rden is dropped; read state -> FETCH if read open, else IDLE.
- Host write: wren with write open and full=0 stores data at ptr; ptr <= ptr+1, wrapping DEPTH-1 -> 0. wren while write is closed is ignored.
  - A write always invalidates the prefetch: read state -> FETCH, empty=1 the next cycle.
- Read state machine:
  - IDLE: empty=1. Read open rising -> FETCH.
  - FETCH: RAM read at ptr issued; empty=1 -> VALID next cycle.
  - VALID: empty=0, data = mem[ptr]. rden -> ptr+1 (wrap), -> FETCH.
  - Read open low in any state -> IDLE.
- Read throughput: 1 word per 2 cycles. rden while empty=1 is ignored.
- First data after open or seek: empty falls 2 cycles after the open edge / addr_update cycle.
- App port:
  - app_rdata <= mem[app_addr] every cycle.
  - app_wren writes mem[app_addr] unless the host writes the same address in the same cycle; then the host wins and app_collision pulses.
  - An app write to the address held in VALID forces read state -> FETCH, so the host never sees stale data.
  - Read-during-write on the app port returns old data.
- Reset mid-transfer: pointer and state return to reset values; memory contents are retained.

Optional Feature:
- Macro XILLY_MEM_EOF_EN.
- Defined:
  - A rden popping word DEPTH-1 does not wrap; the read state enters END: empty=1, eof=1.
  - The write pointer likewise saturates: after a write to DEPTH-1, full=1 and further wren is ignored.
  - END, eof and full clear on addr_update or on the corresponding open going low.
- Undefined: eof tied 0, no END state, pointer wraps as above.

Test Plan:
- Reset, open write, seek 0, write 0x11,0x22,0x33 -> mem[0..2]=11,22,33; app_addr=1 gives app_rdata=0x22 one cycle later.
- Seek 1, open read -> empty falls 2 cycles after the seek cycle, data=0x22; rden -> data=0x33 two cycles later.
- Seek 31 (ADDR_W=5), write 0xAA,0xBB -> mem[31]=AA, mem[0]=BB; with XILLY_MEM_EOF_EN, mem[0] unchanged, full=1.
- Host and app write address 4 in the same cycle (0x5A host, 0xC3 app) -> mem[4]=0x5A, app_collision pulses for 1 cycle.
- Read VALID at addr 2, app writes 0x77 to addr 2 -> empty=1 for 1 cycle, then data=0x77; with EOF_EN, reading word 31 -> eof=1, empty=1 until reseek.
- addr_update asserted together with wren and with rden -> both dropped, ptr = new address; user_reset mid-read -> empty=1, ptr=0, memory intact.
